// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Yout = A - B, one bit per clock, LSB first.
// Result and borrow/overflow/zero flags update together on the final bit; start/busy/done sequencing.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Yout,
  output logic             borrow,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] yout_q, yout_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic bit_a, bit_b, diff_bit, br_next;

  assign bit_a    = a_sh_q[0];
  assign bit_b    = b_sh_q[0];
  assign diff_bit = bit_a ^ bit_b ^ br_q;
  assign br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    br_d     = br_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    yout_d   = yout_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        // start is deliberately ignored here; the operands stay as latched.
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {diff_bit, res_q[WIDTH-1:1]};
        br_d   = br_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          cnt_d    = '0;
          yout_d   = res_d;
          borrow_d = br_next;
          ovf_d    = (a_msb_q != b_msb_q) && (diff_bit != a_msb_q);
          zero_d   = (res_d == '0);
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      yout_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      br_q     <= br_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      yout_q   <= yout_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  // busy/done decode straight from the state register, so both are registered
  // and done lasts exactly the one cycle spent in DONE.
  assign busy      = (state_q == S_BUSY);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;
  assign Yout      = yout_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor for the ALU datapath. It computes Yout = A − B one bit per clock, LSB first, and reports borrow, signed-overflow and zero flags. It is the inverse of the team's combinational ripple adder and trades latency for a single-bit datapath. It uses a start/busy/done handshake so the ALU controller can sequence it.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on a rising edge while in IDLE or DONE
- A  input  WIDTH  minuend; sampled together with start
- B  input  WIDTH  subtrahend; sampled together with start
- Yout  output  WIDTH  registered result A − B modulo 2^WIDTH
- borrow  output  1  unsigned borrow-out (1 iff A < B unsigned)
- ovf  output  1  signed overflow of A − B
- zero  output  1  1 iff the result is 0
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse marking that the result and flags have been updated

## Operation
- Reset is asynchronous and active-low: one clock; all outputs, the state, the counter and internal registers clear to 0; the state goes to IDLE.
- States:
  - IDLE: wait for start.
  - BUSY: process one bit per cycle; the counter runs 0..WIDTH−1.
  - DONE: hold the result.
- IDLE/DONE with start=1: latch A and B into internal shift registers, clear the internal borrow and counter, go to BUSY.
- DONE with start=0 goes to IDLE. IDLE with start=0 stays in IDLE.
- Per BUSY cycle, with a = current A bit, b = current B bit and br = borrow register:
  - d = a ^ b ^ br
  - br_next = (~a & b) | (~(a ^ b) & br)
  - d shifts into the result shift register from the MSB end.
- The counter increments each BUSY cycle. On the cycle with counter == WIDTH−1:
  - Yout ← completed result.
  - borrow ← br_next.
  - ovf ← (A[MSB] != B[MSB]) && (Y[MSB] != A[MSB]), using the latched operands.
  - zero ← (result == 0).
  - State goes to DONE.
- Yout and the flags change only on that completion edge. They hold their previous values during BUSY and until the next completion.
- start while in BUSY is ignored: operands are not re-latched and the sequence is not disturbed.
- A and B may change freely after the start edge.

## Timing
- Edge E0 samples start=1. busy=1 from E0 through edge E_WIDTH.
- Edges E1..E_WIDTH process bits 0..WIDTH−1. Yout and the flags update at E_WIDTH.
- At E_WIDTH: done=1 and busy=0, both registered. done lasts exactly one cycle.
- Latency is WIDTH edges from the start edge to done (8 for the default).
- start=1 at E_{WIDTH+1}, while in DONE: a new operation begins, done=0 and busy=1 after that edge. Back-to-back throughput is one result per WIDTH+1 cycles.
- rst_n low mid-operation: outputs clear immediately, without waiting for a clock edge. The partial result is discarded and no done pulse is produced. After release, the block waits in IDLE.
- No combinational path from any input to any output.

## Test plan
- Basic subtract: A=8'h05, B=8'h03, start at E0 -> at E8 Yout=8'h02, borrow=0, ovf=0, zero=0, done=1 for one cycle; busy was high over E1..E8.
- Unsigned borrow: A=8'h03, B=8'h05 -> Yout=8'hFE, borrow=1, ovf=0, zero=0.
- Signed overflow: A=8'h80, B=8'h01 -> Yout=8'h7F, borrow=0, ovf=1. Second case: A=8'h7F, B=8'hFF -> Yout=8'h80, borrow=1, ovf=1.
- Zero and back-to-back:
  - A=B=8'h55 -> Yout=8'h00, zero=1, borrow=0.
  - start=1 again in DONE with A=8'h10, B=8'h01 -> done after 8 more edges, Yout=8'h0F, zero=0.
- start during BUSY: at E3 drive start=1 with A=8'hFF, B=8'hFF over an 8'h09−8'h04 operation -> result 8'h05 at E8, no restart, a single done pulse.
- Reset mid-op: assert rst_n=0 at cycle 4 of BUSY -> Yout, flags, busy and done go to 0 immediately. After release with no start, outputs stay 0 and no done pulse appears.
